// File: rtl/rr_grant_arbiter_if.sv
// Grant handshake bundle between requesting lanes and the round-robin arbiter.
// The master modport is the arbiter side; the slave modport is the requester/consumer side.
interface rr_grant_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_ack;

  modport master (
    input  req,
    input  gnt_ack,
    output gnt,
    output gnt_valid,
    output gnt_idx
  );

  modport slave (
    output req,
    output gnt_ack,
    input  gnt,
    input  gnt_valid,
    input  gnt_idx
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Registered work-conserving round-robin arbiter: grant 1 cycle after req, back-to-back on ack.
// A held grant stays stable until acked or its own request drops (abort, 1-cycle bubble).

module ppc_unit #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_onehot,
  output logic [N-1:0] o_therm
);
  logic w_acc;

  // Prefix OR: every bit at or above the set pointer bit becomes 1.
  always_comb begin
    o_therm = '0;
    w_acc   = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_acc      = w_acc | i_onehot[i];
      o_therm[i] = w_acc;
    end
  end
endmodule

module rr_grant_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  rr_grant_arbiter_if.master  arb
);
  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [IDX_W-1:0]   w_gnt_idx_nxt;
  logic               r_gnt_valid;
  logic               w_gnt_valid_nxt;

  logic               w_accept;
  logic [IDX_W-1:0]   w_ptr_inc;
  logic [IDX_W-1:0]   w_sel_ptr;
  logic [NUM_REQ-1:0] w_sel_req;
  logic [NUM_REQ-1:0] w_ptr_onehot;
  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_hi;
  logic [IDX_W-1:0]   w_winner;
  logic [NUM_REQ-1:0] w_winner_oh;
  logic               w_any;
  logic               w_held_req;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  assign w_accept   = (r_state == HOLD) && arb.gnt_ack;
  assign w_ptr_inc  = (r_gnt_idx == LAST_IDX) ? '0 : r_gnt_idx + IDX_W'(1);
  assign w_held_req = arb.req[r_gnt_idx];

  // On accept, re-arbitrate this cycle against the advanced pointer with the winner removed.
  assign w_sel_ptr    = w_accept ? w_ptr_inc : r_ptr;
  assign w_sel_req    = (r_state == HOLD) ? (arb.req & ~r_gnt) : arb.req;
  assign w_ptr_onehot = NUM_REQ'(1) << w_sel_ptr;

  ppc_unit #(
    .N(NUM_REQ)
  ) u_ppc (
    .i_onehot (w_ptr_onehot),
    .o_therm  (w_mask)
  );

  assign w_hi        = w_sel_req & w_mask;
  assign w_winner    = lowest_idx((|w_hi) ? w_hi : w_sel_req);
  assign w_winner_oh = NUM_REQ'(1) << w_winner;
  assign w_any       = |w_sel_req;

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gnt_nxt       = w_winner_oh;
          w_gnt_idx_nxt   = w_winner;
          w_gnt_valid_nxt = 1'b1;
          w_state_nxt     = HOLD;
        end
      end
      HOLD: begin
        if (arb.gnt_ack) begin
          w_ptr_nxt = w_ptr_inc;
          if (w_any) begin
            w_gnt_nxt       = w_winner_oh;
            w_gnt_idx_nxt   = w_winner;
            w_gnt_valid_nxt = 1'b1;
          end else begin
            w_gnt_nxt       = '0;
            w_gnt_idx_nxt   = '0;
            w_gnt_valid_nxt = 1'b0;
            w_state_nxt     = IDLE;
          end
        end else if (!w_held_req) begin
          w_gnt_nxt       = '0;
          w_gnt_idx_nxt   = '0;
          w_gnt_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_gnt_nxt       = '0;
        w_gnt_idx_nxt   = '0;
        w_gnt_valid_nxt = 1'b0;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
    end
  end

  assign arb.gnt       = r_gnt;
  assign arb.gnt_idx   = r_gnt_idx;
  assign arb.gnt_valid = r_gnt_valid;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: reset, rotation, sparse, stall, abort, reset mid-hold.
module tb_rr_grant_arbiter;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  rr_grant_arbiter_if #(.NUM_REQ(8)) arb_if ();

  rr_grant_arbiter #(.NUM_REQ(8)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (arb_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input int lane);
    logic [7:0] oh;
    oh = 8'(1) << lane;
    chk({tag, ".gnt"}, 32'(arb_if.gnt), 32'(oh));
    chk({tag, ".vld"}, 32'(arb_if.gnt_valid), 32'd1);
    chk({tag, ".idx"}, 32'(arb_if.gnt_idx), 32'(lane));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gnt"}, 32'(arb_if.gnt), 32'd0);
    chk({tag, ".vld"}, 32'(arb_if.gnt_valid), 32'd0);
  endtask

  initial begin
    int exp_rot[9];
    int exp_sp[4];
    tests = 0;
    fails = 0;
    exp_sp = '{2, 5, 2, 5};

    // T1 reset held two cycles with requests and ack active
    reset = 1'b1;
    arb_if.req = 8'hFF;
    arb_if.gnt_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle($sformatf("t1_rst%0d", i));
      chk($sformatf("t1_rst%0d.idx", i), 32'(arb_if.gnt_idx), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk_idle("t1_release");
    chk("t1_release.idx", 32'(arb_if.gnt_idx), 32'd0);
    tick();
    chk_lane("t1_first", 0);

    // T2 rotation with all lanes requesting, ack every cycle
    for (int i = 0; i < 9; i++) exp_rot[i] = (i + 1) % 8;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_lane($sformatf("t2_rot%0d", i), exp_rot[i]);
    end

    // T3 sparse lanes 2 and 5
    arb_if.req = 8'b0010_0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_lane($sformatf("t3_sparse%0d", i), exp_sp[i]);
    end
    tick();
    chk_lane("t3_hold2", 2);
    arb_if.req = 8'b0000_0100;
    tick();
    chk_idle("t3_drain");

    // T4 stall from a fresh pointer
    reset = 1'b1;
    arb_if.gnt_ack = 1'b0;
    arb_if.req = 8'h00;
    tick();
    reset = 1'b0;
    arb_if.req = 8'h81;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_lane($sformatf("t4_stall%0d", i), 0);
    end
    arb_if.gnt_ack = 1'b1;
    tick();
    chk_lane("t4_after_ack", 7);
    tick();
    chk_lane("t4_wrap", 0);
    tick();
    chk_lane("t4_wrap2", 7);

    // T5 abort: ptr is 0 after the accept of lane 7
    arb_if.req = 8'h08;
    tick();
    chk_lane("t5_grant3", 3);
    arb_if.req = 8'h00;
    arb_if.gnt_ack = 1'b0;
    tick();
    chk_idle("t5_abort");
    arb_if.req = 8'h18;
    tick();
    chk_lane("t5_regrant3", 3);
    arb_if.req = 8'hF8;
    tick();
    chk_lane("t5_others_change", 3);
    // ack wins over a dropped request in the same cycle
    arb_if.req = 8'h10;
    arb_if.gnt_ack = 1'b1;
    tick();
    chk_lane("t5_ack_wins", 4);

    // T6 reset while lane 4 is held
    arb_if.gnt_ack = 1'b0;
    arb_if.req = 8'hFF;
    reset = 1'b1;
    tick();
    chk_idle("t6_reset");
    chk("t6_reset.idx", 32'(arb_if.gnt_idx), 32'd0);
    reset = 1'b0;
    tick();
    chk_lane("t6_first", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
